img_axil_reg_slave: RTL and testbench
=====================================

Name: img_axil_reg_slave

Overview:
- AXI4-Lite slave (responder) register file for the S00_AXI control port of the image size converter.
- Terminates the transactions driven by the VIP master: accepts writes with byte strobes, returns read data and responses.
- Exposes register contents and per-register write pulses to the datapath.
- Sits between the BD AXI interconnect and the converter core.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, byte address width.
- NUM_REGS, 4, number of 32-bit registers; must be ≤ 2**(ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous assert, active-low
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  DATA_WIDTH  / S_AXI_WSTRB  in  DATA_WIDTH/8
- S_AXI_WVALID  in  1  / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2  / S_AXI_BVALID  out  1  / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  ADDR_WIDTH  / S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  DATA_WIDTH  / S_AXI_RRESP  out  2
- S_AXI_RVALID  out  1  / S_AXI_RREADY  in  1
- reg_out  out  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [32i+31:32i]
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after register i is written

Behaviour:
- Single clock ACLK. ARESETN is asynchronous, active-low.
- Values while ARESETN=0: all registers 0; all READY and VALID outputs 0; BRESP=RRESP=0; RDATA=0; reg_wr_pulse=0.
- AWREADY, WREADY and ARREADY rise on the first ACLK edge after ARESETN deasserts.
- Decode: index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored. An index ≥ NUM_REGS is out of range.
- Write channel, FSM states:
  - W_ACCEPT: AWREADY = no address held; WREADY = no data held. AW and W are captured independently, in any order or the same cycle. When both are held → W_COMMIT.
  - W_COMMIT (1 cycle):
    - In range: for each byte k with WSTRB[k]=1, reg[index] byte k ← WDATA byte k, and reg_wr_pulse[index]=1 on the next cycle. A write with WSTRB=0 still pulses.
    - Out of range: no register change, no pulse.
    - BVALID←1. BRESP=OKAY (00) in range, SLVERR (10) out of range. → W_RESP.
  - W_RESP: AWREADY=WREADY=0; hold BVALID and BRESP until BREADY=1. On handshake: BVALID←0, clear held flags → W_ACCEPT.
  - Minimum write latency: AW/W handshake → BVALID is 2 cycles.
- Read channel, FSM states:
  - R_IDLE: ARREADY=1. On ARVALID handshake, capture the register value that same cycle. RDATA is that value, or 0 with RRESP=SLVERR if out of range. RVALID←1 next edge → R_RESP.
  - R_RESP: ARREADY=0; hold RDATA, RRESP and RVALID until RREADY=1, then → R_IDLE.
- Simultaneous read and write of the same register: a read whose AR handshake falls on the W_COMMIT cycle returns the old value.
- Read and write channels are fully independent; neither blocks the other.
- Reset mid-transaction: pending AW/W/AR is discarded, VALIDs drop asynchronously, registers clear. No response is issued for an aborted transaction.
- Only one outstanding transaction per direction.

Decomposition:
- Package img_axil_pkg holds:
  - localparams RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - typedefs for the write FSM (W_ACCEPT, W_COMMIT, W_RESP) and read FSM (R_IDLE, R_RESP) state enums.
- Optional sub-module img_axil_strb_merge: combinational byte-lane merge of old data, WDATA and WSTRB. Everything else lives in the top module.

Test Plan:
- Sequential writes of 1,2,3,4 to 0x0,0x4,0x8,0xC, then reads → RDATA 1,2,3,4, all BRESP/RRESP=OKAY, reg_wr_pulse bits 0..3 each pulse once.
- Write 0xFFFFFFFF to 0x4, then write 0x12345678 with WSTRB=0101 → read 0x4 returns 0xFF34FF78.
- WVALID 3 cycles before AWVALID on 0x8 with data 0xA5 → WREADY drops after the W handshake; BVALID 2 cycles after the AW handshake; reg 2 = 0xA5.
- BREADY held low 5 cycles → BVALID stays 1 and AWREADY/WREADY stay 0 for those cycles; a concurrent read of 0x0 completes normally.
- With NUM_REGS=2, ADDR_WIDTH=4: write and read at 0xC → BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no reg_wr_pulse, regs unchanged.
- ARESETN asserted while BVALID=1 after a write of 0x55 to 0x0 → BVALID=0 immediately; reg 0 reads 0 after release.

Source files
------------

// File: rtl/img_axil_pkg.sv
// rtl/img_axil_pkg.sv - shared response codes and FSM state types for the AXI-Lite register slave
package img_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_ACCEPT,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/img_axil_strb_merge.sv
// rtl/img_axil_strb_merge.sv - byte-lane merge of old register data with strobed write data
module img_axil_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged
);

    // Each enabled byte lane takes the new data, the rest keep the old value
    always_comb begin
        merged = old_data;
        for (int k = 0; k < DATA_WIDTH / 8; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_data[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/img_axil_reg_slave.sv
// rtl/img_axil_reg_slave.sv - AXI4-Lite register file for the image size converter control port
module img_axil_reg_slave
    import img_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    wr_state_t             wr_state;
    logic                  aw_held;
    logic                  w_held;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [NUM_REGS-1:0]   pulse_q;

    rd_state_t             rd_state;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  unused_bits;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    assign aw_hs       = S_AXI_AWVALID && awready_q;
    assign w_hs        = S_AXI_WVALID && wready_q;
    assign ar_hs       = S_AXI_ARVALID && arready_q;
    assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Current contents of the register targeted by the held write address
    always_comb begin
        wr_old = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                wr_old = regs[i];
            end
        end
    end

    // Register value addressed by the incoming read; zero when out of range
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_val = regs[i];
            end
        end
    end

    img_axil_strb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_merge (
        .old_data (wr_old),
        .new_data (wdata_q),
        .strb     (wstrb_q),
        .merged   (wr_merged)
    );

    // Write FSM: independent AW/W capture, one-cycle commit, response hold
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state  <= W_ACCEPT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            wr_idx    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            pulse_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pulse_q <= '0;
            case (wr_state)
                W_ACCEPT: begin
                    if (aw_hs) begin
                        wr_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
                        aw_held <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= S_AXI_WDATA;
                        wstrb_q <= S_AXI_WSTRB;
                        w_held  <= 1'b1;
                    end
                    awready_q <= !(aw_held || aw_hs);
                    wready_q  <= !(w_held || w_hs);
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        wr_state <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_idx == IDX_W'(i)) begin
                            regs[i]    <= wr_merged;
                            pulse_q[i] <= 1'b1;
                        end
                    end
                    bresp_q  <= in_range(wr_idx) ? RESP_OKAY : RESP_SLVERR;
                    bvalid_q <= 1'b1;
                    wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_state  <= W_ACCEPT;
                    end
                end
                default: wr_state <= W_ACCEPT;
            endcase
        end
    end

    // Read FSM: register sampled on the AR handshake edge, held until RREADY
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_q   <= rd_val;
                        rresp_q   <= in_range(rd_idx) ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rd_state  <= R_RESP;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_state  <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Flatten the register array onto the datapath bus
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[DATA_WIDTH*i +: DATA_WIDTH] = regs[i];
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_img_axil_reg_slave.sv
// tb/tb_img_axil_reg_slave.sv - directed self-checking bench for the AXI-Lite register slave
module tb_img_axil_reg_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [3:0]  araddr;
    logic [2:0]  awprot = 3'b000;
    logic [2:0]  arprot = 3'b000;
    logic        awvalid;
    logic        wvalid;
    logic        bready;
    logic        arvalid;
    logic        rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [127:0] reg_out;
    logic [3:0]  pulse;

    logic        awready2, wready2, bvalid2, arready2, rvalid2;
    logic [1:0]  bresp2, rresp2;
    logic [31:0] rdata2;
    logic [63:0] reg_out2;
    logic [1:0]  pulse2;

    int checks = 0;
    int errors = 0;
    int pulse_cnt [4];
    int pulse2_total = 0;

    always #5 clk = ~clk;

    img_axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(4)) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .reg_wr_pulse(pulse)
    );

    img_axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(2)) dut2 (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready2),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready2),
        .S_AXI_BRESP(bresp2), .S_AXI_BVALID(bvalid2), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready2),
        .S_AXI_RDATA(rdata2), .S_AXI_RRESP(rresp2), .S_AXI_RVALID(rvalid2), .S_AXI_RREADY(rready),
        .reg_out(reg_out2), .reg_wr_pulse(pulse2)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (pulse[i]) pulse_cnt[i]++;
        for (int i = 0; i < 2; i++) if (pulse2[i]) pulse2_total++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r1, output logic [1:0] r2);
        int  n;
        bit  awd;
        bit  wd;
        n = 0; awd = 1'b0; wd = 1'b0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(awd && wd) && n < 50) begin
            if (awvalid && awready) awd = 1'b1;
            if (wvalid && wready) wd = 1'b1;
            @(negedge clk);
            n++;
            if (awd) awvalid = 1'b0;
            if (wd) wvalid = 1'b0;
        end
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("write_timeout", 128'(n < 50), 128'(1));
        r1 = bresp;
        r2 = bresp2;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d1, output logic [1:0] r1,
                           output logic [31:0] d2, output logic [1:0] r2);
        int n;
        n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("read_timeout", 128'(n < 50), 128'(1));
        d1 = rdata; r1 = rresp; d2 = rdata2; r2 = rresp2;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0]  r1, r2;
        logic [31:0] d1, d2;
        int          p2_before;

        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        rst_n = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1; awaddr = 4'h0; araddr = 4'h0;
        wdata = 32'h0; wstrb = 4'h0;

        repeat (2) @(negedge clk);
        check("reset_handshake", 128'({awready, wready, arready, bvalid, rvalid}), 128'(5'b00000));
        check("reset_resp_data", 128'({bresp, rresp, rdata}), 128'(0));
        check("reset_regs", reg_out, 128'(0));
        check("reset_pulse", 128'(pulse), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 128'({awready, wready, arready}), 128'(3'b111));

        // Sequential writes 1..4 then read-back
        for (int i = 0; i < 4; i++) begin
            do_write(4'(i * 4), 32'(i + 1), 4'hF, r1, r2);
            check("seq_bresp", 128'(r1), 128'(2'b00));
        end
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), d1, r1, d2, r2);
            check("seq_rdata", 128'(d1), 128'(i + 1));
            check("seq_rresp", 128'(r1), 128'(2'b00));
            check("seq_pulse_count", 128'(pulse_cnt[i]), 128'(1));
        end
        check("seq_reg_out", reg_out, {32'd4, 32'd3, 32'd2, 32'd1});

        // Byte strobes
        do_write(4'h4, 32'hFFFF_FFFF, 4'hF, r1, r2);
        do_write(4'h4, 32'h1234_5678, 4'b0101, r1, r2);
        do_read(4'h4, d1, r1, d2, r2);
        check("strobe_rdata", 128'(d1), 128'(32'hFF34_FF78));
        check("strobe_pulse_count", 128'(pulse_cnt[1]), 128'(3));

        // W three cycles ahead of AW
        @(negedge clk);
        awaddr = 4'h8; wdata = 32'hA5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        check("w_early_wready", 128'(wready), 128'(1));
        @(negedge clk);
        wvalid = 1'b0;
        check("w_early_wready_drop", 128'(wready), 128'(0));
        @(negedge clk);
        @(negedge clk);
        check("w_early_wready_held", 128'(wready), 128'(0));
        awvalid = 1'b1;
        check("w_early_awready", 128'(awready), 128'(1));
        @(negedge clk);
        awvalid = 1'b0;
        check("w_early_bvalid_1cyc", 128'(bvalid), 128'(0));
        @(negedge clk);
        check("w_early_bvalid_2cyc", 128'(bvalid), 128'(1));
        check("w_early_pulse", 128'(pulse), 128'(4'b0100));
        check("w_early_bresp", 128'(bresp), 128'(2'b00));
        bready = 1'b1;
        @(negedge clk);
        check("w_early_bvalid_clear", 128'(bvalid), 128'(0));
        do_read(4'h8, d1, r1, d2, r2);
        check("w_early_rdata", 128'(d1), 128'(32'hA5));

        // BREADY held low with a concurrent read
        @(negedge clk);
        awaddr = 4'h0; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bhold_bvalid", 128'(bvalid), 128'(1));
            check("bhold_readies", 128'({awready, wready}), 128'(2'b00));
            if (k == 0) begin
                check("bhold_arready", 128'(arready), 128'(1));
                araddr = 4'h0; arvalid = 1'b1; rready = 1'b1;
            end
            if (k == 1) begin
                check("bhold_rvalid", 128'(rvalid), 128'(1));
                check("bhold_rdata", 128'(rdata), 128'(32'h77));
                check("bhold_rresp", 128'(rresp), 128'(2'b00));
                arvalid = 1'b0;
            end
            if (k == 2) check("bhold_rvalid_clear", 128'(rvalid), 128'(0));
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("bhold_release", 128'({bvalid, awready, wready}), 128'(3'b011));

        // Out-of-range access on the two-register instance
        p2_before = pulse2_total;
        do_write(4'hC, 32'hDEAD_BEEF, 4'hF, r1, r2);
        check("oor_bresp", 128'(r2), 128'(2'b10));
        check("oor_bresp_inrange_inst", 128'(r1), 128'(2'b00));
        do_read(4'hC, d1, r1, d2, r2);
        check("oor_rresp", 128'(r2), 128'(2'b10));
        check("oor_rdata", 128'(d2), 128'(0));
        check("oor_inrange_rdata", 128'(d1), 128'(32'hDEAD_BEEF));
        check("oor_no_pulse", 128'(pulse2_total), 128'(p2_before));
        check("oor_regs_unchanged", 128'(reg_out2), 128'({32'hFF34_FF78, 32'h0000_0077}));

        // Reset while a write response is pending
        @(negedge clk);
        awaddr = 4'h0; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("rst_mid_bvalid_before", 128'(bvalid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_bvalid_async", 128'(bvalid), 128'(0));
        check("rst_mid_regs", reg_out, 128'(0));
        @(negedge clk);
        rst_n = 1'b1; bready = 1'b1;
        @(negedge clk);
        do_read(4'h0, d1, r1, d2, r2);
        check("rst_mid_rdata", 128'(d1), 128'(0));
        check("rst_mid_no_bvalid", 128'(bvalid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
